// File: rtl/fifo_ctrl.sv
// FIFO pointer/occupancy controller for an external single-port-read, single-port-write memory.
// Optional FIFO_CTRL_STICKY_ERR_EN: overflow/underflow stay set until reset instead of pulsing.
module fifo_ctrl #(
    parameter int MEM_DEPTH = 8,
    parameter int PTR_W     = 3,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             push,
    input  logic             pop,
    output logic             wr_en,
    output logic             rd_en,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic             valid_out,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(MEM_DEPTH);
    localparam logic [PTR_W:0] AF_CNT   = (PTR_W+1)'(AF_THRESH);
    localparam logic [PTR_W:0] AE_CNT   = (PTR_W+1)'(AE_THRESH);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_nxt_s;
    logic             valid_r;
    logic             overflow_r;
    logic             underflow_r;
    logic             full_s;
    logic             empty_s;
    logic             wr_en_s;
    logic             rd_en_s;
    logic             ovf_evt_s;
    logic             unf_evt_s;

    // Power-of-two depth lets the natural wrap of the pointer width do the modulo.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return ptr + {{(PTR_W-1){1'b0}}, 1'b1};
    endfunction

    // Status decodes of the registered occupancy and request qualification.
    always_comb begin
        full_s    = (count_r == FULL_CNT);
        empty_s   = (count_r == {(PTR_W+1){1'b0}});
        rd_en_s   = reset_L & pop & ~empty_s;
        // A push into a full FIFO is legal only when a pop frees the slot in the same cycle.
        wr_en_s   = reset_L & push & (~full_s | rd_en_s);
        ovf_evt_s = push & full_s & ~rd_en_s;
        unf_evt_s = pop & empty_s;
    end

    // Next occupancy: simultaneous read and write leave it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_nxt_s = count_r + {{PTR_W{1'b0}}, 1'b1};
            2'b01:   count_nxt_s = count_r - {{PTR_W{1'b0}}, 1'b1};
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer, occupancy, read-valid and error-flag registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {(PTR_W+1){1'b0}};
            valid_r     <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wr_ptr_r <= wr_en_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
            rd_ptr_r <= rd_en_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
            count_r  <= count_nxt_s;
            valid_r  <= rd_en_s;
`ifdef FIFO_CTRL_STICKY_ERR_EN
            overflow_r  <= overflow_r | ovf_evt_s;
            underflow_r <= underflow_r | unf_evt_s;
`else
            overflow_r  <= ovf_evt_s;
            underflow_r <= unf_evt_s;
`endif
        end
    end

    assign wr_en        = wr_en_s;
    assign rd_en        = rd_en_s;
    assign wr_ptr       = wr_ptr_r;
    assign rd_ptr       = rd_ptr_r;
    assign count        = count_r;
    assign valid_out    = valid_r;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_r >= AF_CNT);
    assign almost_empty = (count_r <= AE_CNT);
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios plus random traffic against a queue model.
module tb_fifo_ctrl;

    localparam int D  = 8;
    localparam int AF = 6;
    localparam int AE = 2;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       push;
    logic       pop;
    logic       wr_en;
    logic       rd_en;
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic       valid_out;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int tests = 0;
    int fails = 0;

    // Model: queue holds the memory address of every stored word, oldest first.
    int q[$];
    int m_wp, m_rp, m_valid, m_ovf, m_unf;
`ifdef FIFO_CTRL_STICKY_ERR_EN
    localparam int STICKY = 1;
`else
    localparam int STICKY = 0;
`endif

    fifo_ctrl #(.MEM_DEPTH(D), .PTR_W(3), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk(clk), .reset_L(reset_L), .push(push), .pop(pop),
        .wr_en(wr_en), .rd_en(rd_en), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
        .valid_out(valid_out), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_wp = 0; m_rp = 0; m_valid = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic chk_state(input string ctx);
        int n;
        n = q.size();
        chk({ctx, ":count"},     32'(count),        n);
        chk({ctx, ":wr_ptr"},    32'(wr_ptr),       m_wp);
        chk({ctx, ":rd_ptr"},    32'(rd_ptr),       m_rp);
        chk({ctx, ":full"},      32'(full),         (n == D)  ? 1 : 0);
        chk({ctx, ":empty"},     32'(empty),        (n == 0)  ? 1 : 0);
        chk({ctx, ":afull"},     32'(almost_full),  (n >= AF) ? 1 : 0);
        chk({ctx, ":aempty"},    32'(almost_empty), (n <= AE) ? 1 : 0);
        chk({ctx, ":valid_out"}, 32'(valid_out),    m_valid);
        chk({ctx, ":overflow"},  32'(overflow),     m_ovf);
        chk({ctx, ":underflow"}, 32'(underflow),    m_unf);
    endtask

    // One clock cycle with the given requests; called from just after an active edge.
    task automatic step(input string ctx, input logic p, input logic r);
        int n, e_rd, e_wr, ovf_ev, unf_ev;
        push = p;
        pop  = r;
        #1;
        n    = q.size();
        e_rd = (r && n > 0) ? 1 : 0;
        e_wr = (p && (n < D || e_rd == 1)) ? 1 : 0;
        ovf_ev = (p && n == D && e_rd == 0) ? 1 : 0;
        unf_ev = (r && n == 0) ? 1 : 0;
        chk({ctx, ":rd_en"}, 32'(rd_en), e_rd);
        chk({ctx, ":wr_en"}, 32'(wr_en), e_wr);
        if (e_rd == 1) chk({ctx, ":rd_addr"}, 32'(rd_ptr), q[0]);
        @(posedge clk);
        #1;
        if (e_rd == 1) begin
            void'(q.pop_front());
            m_rp = (m_rp + 1) % D;
        end
        if (e_wr == 1) begin
            q.push_back(m_wp);
            m_wp = (m_wp + 1) % D;
        end
        m_valid = e_rd;
        m_ovf = (STICKY == 1) ? (m_ovf | ovf_ev) : ovf_ev;
        m_unf = (STICKY == 1) ? (m_unf | unf_ev) : unf_ev;
        chk_state(ctx);
    endtask

    initial begin
        reset_L = 1'b0;
        push    = 1'b1;
        pop     = 1'b1;
        model_reset();
        #3;
        chk("rst:wr_en", 32'(wr_en), 0);
        chk("rst:rd_en", 32'(rd_en), 0);
        chk_state("rst");
        @(negedge clk);
        reset_L = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        @(posedge clk);
        #1;
        chk_state("post_rst");

        for (int i = 0; i < 8; i++) step("fill", 1'b1, 1'b0);
        step("full_push", 1'b1, 1'b0);
        step("idle_after_ovf", 1'b0, 1'b0);
        step("full_pushpop", 1'b1, 1'b1);
        step("full_pushpop2", 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1);
        step("extra_pop", 1'b0, 1'b1);
        step("empty_pushpop", 1'b1, 1'b1);
        step("pop_one", 1'b0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = (i < 200) ? 65 : 35;
            step("rand", ($urandom_range(0, 99) < bias) ? 1'b1 : 1'b0,
                         ($urandom_range(0, 99) < (100 - bias)) ? 1'b1 : 1'b0);
        end

        while (q.size() > 0) step("pre_reset_drain", 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step("fill5", 1'b1, 1'b0);
        push = 1'b1;
        pop  = 1'b1;
        #2;
        reset_L = 1'b0;
        #1;
        model_reset();
        chk("async_rst:wr_en", 32'(wr_en), 0);
        chk("async_rst:rd_en", 32'(rd_en), 0);
        chk_state("async_rst");
        @(negedge clk);
        reset_L = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        @(posedge clk);
        #1;
        chk_state("after_async_rst");

        for (int i = 0; i < 100; i++)
            step("rand2", ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
